// File: rtl/pio_display_input_ctrl_if.sv
// pio_display_input_ctrl_if: Avalon-MM slave bus bundle (address, read/write strobes, write data, registered read data)
interface pio_display_input_ctrl_if;
  logic [3:0] avs_address;
  logic avs_read;
  logic avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
  modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
endinterface

// File: rtl/pio_display_input_ctrl.sv
// pio_display_input_ctrl: Avalon-MM PIO with debounced inputs, edge capture/IRQ and N-digit muxed 7-seg scan; ports: clk_clk, rst_reset, avs (bus), irq, in_pins, seg_out, digit_sel_n
module pio_display_input_ctrl #(
  parameter int DIGITS = 4,
  parameter int IN_W = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SCAN_DIV = 1000
) (
  input logic clk_clk,
  input logic rst_reset,
  pio_display_input_ctrl_if.slave avs,
  output logic irq,
  input logic [IN_W-1:0] in_pins,
  output logic [6:0] seg_out,
  output logic [DIGITS-1:0] digit_sel_n
);
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [IN_W-1:0] sync1_q, sync2_q, stable_q, stable_d, edge_q, edge_d, mask_q, w1c;
  logic [CW-1:0] cnt_q [IN_W];
  logic [CW-1:0] cnt_d [IN_W];
  logic [PW-1:0] presc_q;
  logic [2:0] idx_q;
  logic mode_q, irq_q, wr_digit, scan_tc;
  logic [7:0] digit_q [8];
  logic [7:0] cur;
  logic [6:0] seg_q, seg_d;
  logic [DIGITS-1:0] sel_q;
  logic [31:0] rdata_q, rdata_d;
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < IN_W; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) stable_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  assign w1c = (avs.avs_write && avs.avs_address == 4'h1) ? avs.avs_writedata[IN_W-1:0] : '0;
  assign edge_d = (edge_q & ~w1c) | (stable_d & ~stable_q);
  assign wr_digit = avs.avs_write && avs.avs_address[3] && int'(avs.avs_address[2:0]) < DIGITS;
  assign scan_tc = presc_q == PW'(SCAN_DIV - 1);
  assign cur = digit_q[idx_q];
  assign seg_d = cur[7] ? 7'h7F : mode_q ? ~cur[6:0] : HEX[cur[3:0]];
  always_comb begin
    rdata_d = '0;
    case (avs.avs_address)
      4'h0: rdata_d[IN_W-1:0] = stable_q;
      4'h1: rdata_d[IN_W-1:0] = edge_q;
      4'h2: rdata_d[IN_W-1:0] = mask_q;
      4'h3: rdata_d[0] = mode_q;
      default: rdata_d[7:0] = (avs.avs_address[3] && int'(avs.avs_address[2:0]) < DIGITS) ? digit_q[avs.avs_address[2:0]] : 8'h00;
    endcase
  end
  always_ff @(posedge clk_clk) begin
    if (rst_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      edge_q <= '0;
      mask_q <= '0;
      mode_q <= 1'b0;
      irq_q <= 1'b0;
      presc_q <= '0;
      idx_q <= '0;
      seg_q <= 7'h7F;
      sel_q <= ~DIGITS'(1);
      rdata_q <= '0;
      for (int i = 0; i < IN_W; i++) cnt_q[i] <= '0;
      for (int k = 0; k < 8; k++) digit_q[k] <= 8'h80;
    end else begin
      sync1_q <= in_pins;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      edge_q <= edge_d;
      for (int i = 0; i < IN_W; i++) cnt_q[i] <= cnt_d[i];
      irq_q <= |(edge_q & mask_q);
      if (avs.avs_write && avs.avs_address == 4'h2) mask_q <= avs.avs_writedata[IN_W-1:0];
      if (avs.avs_write && avs.avs_address == 4'h3) mode_q <= avs.avs_writedata[0];
      if (wr_digit) digit_q[avs.avs_address[2:0]] <= avs.avs_writedata[7:0];
      if (avs.avs_read) rdata_q <= rdata_d;
      presc_q <= scan_tc ? '0 : presc_q + 1'b1;
      if (scan_tc) idx_q <= idx_q == 3'(DIGITS - 1) ? '0 : idx_q + 1'b1;
      if (presc_q == '0) begin
        seg_q <= seg_d;
        sel_q <= ~(DIGITS'(1) << idx_q);
      end
    end
  end
  assign avs.avs_readdata = rdata_q;
  assign irq = irq_q;
  assign seg_out = seg_q;
  assign digit_sel_n = sel_q;
endmodule

// File: tb/tb_pio_display_input_ctrl.sv
// tb_pio_display_input_ctrl: randomized self-checking bench for pio_display_input_ctrl against a behavioural model
module tb_pio_display_input_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] pins = '0;
  logic irq;
  logic [6:0] seg;
  logic [3:0] sel;
  int n_chk = 0;
  int n_pass = 0;
  pio_display_input_ctrl_if bus();
  pio_display_input_ctrl #(.DIGITS(4), .IN_W(4), .DEBOUNCE_CYC(16), .SCAN_DIV(4)) dut (
    .clk_clk(clk), .rst_reset(rst), .avs(bus), .irq(irq), .in_pins(pins), .seg_out(seg), .digit_sel_n(sel)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] exp_seg(input logic [7:0] v, input logic m);
    logic [6:0] h;
    case (v[3:0])
      4'h0: h = 7'h40; 4'h1: h = 7'h79; 4'h2: h = 7'h24; 4'h3: h = 7'h30;
      4'h4: h = 7'h19; 4'h5: h = 7'h12; 4'h6: h = 7'h02; 4'h7: h = 7'h78;
      4'h8: h = 7'h00; 4'h9: h = 7'h10; 4'hA: h = 7'h08; 4'hB: h = 7'h03;
      4'hC: h = 7'h46; 4'hD: h = 7'h21; 4'hE: h = 7'h06; default: h = 7'h0E;
    endcase
    return v[7] ? 7'h7F : m ? ~v[6:0] : h;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    pins = '0;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    tick();
    bus.avs_write = 1'b0;
  endtask
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    tick();
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask
  task automatic sync_digit0(output bit ok);
    logic [3:0] prev;
    prev = sel;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (sel == 4'b1110 && prev != 4'b1110) ok = 1'b1;
      prev = sel;
    end
  endtask
  task automatic test_reset();
    logic [31:0] d, e;
    do_reset();
    n_chk++; if (seg !== 7'h7F) $display("FAIL reset_seg got %h exp 7f", seg); else n_pass++;
    n_chk++; if (sel !== 4'b1110) $display("FAIL reset_sel got %b exp 1110", sel); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else n_pass++;
    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), d);
      e = (a >= 8 && a < 12) ? 32'h80 : 32'h0;
      n_chk++; if (d !== e) $display("FAIL reset_reg[%0d] got %h exp %h", a, d, e); else n_pass++;
    end
  endtask
  task automatic test_bus();
    logic [31:0] d, r;
    do_reset();
    bus_write(4'h0, 32'hF);
    bus_read(4'h0, d);
    n_chk++; if (d !== 32'h0) $display("FAIL bus_datain_ro got %h exp 0", d); else n_pass++;
    bus_read(4'h5, d);
    n_chk++; if (d !== 32'h0) $display("FAIL bus_unmapped got %h exp 0", d); else n_pass++;
    r = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(1, 15));
    bus_write(4'h2, r);
    bus_write(4'h3, r);
    bus.avs_address = 4'h2;
    bus.avs_read = 1'b1;
    n_chk++; if (bus.avs_readdata !== 32'h0) $display("FAIL bus_pre_edge got %h exp 0", bus.avs_readdata); else n_pass++;
    tick();
    bus.avs_read = 1'b0;
    bus.avs_address = 4'h3;
    n_chk++; if (bus.avs_readdata !== (r & 32'hF)) $display("FAIL bus_latency got %h exp %h", bus.avs_readdata, r & 32'hF); else n_pass++;
    tick();
    n_chk++; if (bus.avs_readdata !== (r & 32'hF)) $display("FAIL bus_hold got %h exp %h", bus.avs_readdata, r & 32'hF); else n_pass++;
    bus_read(4'h3, d);
    n_chk++; if (d !== (r & 32'h1)) $display("FAIL bus_mode got %h exp %h", d, r & 32'h1); else n_pass++;
    bus_write(4'hC, 32'h55);
    bus_read(4'hC, d);
    n_chk++; if (d !== 32'h0) $display("FAIL bus_digit_oob got %h exp 0", d); else n_pass++;
  endtask
  task automatic test_hex_scan();
    logic [6:0] es [4];
    logic [3:0] ss;
    bit ok;
    es = '{7'h79, 7'h08, 7'h0E, 7'h00};
    do_reset();
    bus_write(4'h8, 32'h01);
    bus_write(4'h9, 32'h0A);
    bus_write(4'hA, 32'h0F);
    bus_write(4'hB, 32'h08);
    sync_digit0(ok);
    n_chk++; if (!ok) $display("FAIL hex_align got timeout exp digit0 slot"); else n_pass++;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) tick();
      ss = ~(4'b0001 << ((t / 4) % 4));
      n_chk++; if (sel !== ss || seg !== es[(t / 4) % 4]) $display("FAIL hex_scan t=%0d got %b/%h exp %b/%h", t, sel, seg, ss, es[(t / 4) % 4]); else n_pass++;
    end
  endtask
  task automatic test_raw_blank();
    bit ok;
    do_reset();
    bus_write(4'h3, 32'h1);
    bus_write(4'h8, 32'h7F);
    sync_digit0(ok);
    n_chk++; if (!ok || seg !== 7'h00) $display("FAIL raw_seg got %h exp 00", seg); else n_pass++;
    bus_write(4'h8, 32'h80);
    sync_digit0(ok);
    n_chk++; if (!ok || seg !== 7'h7F) $display("FAIL blank_seg got %h exp 7f", seg); else n_pass++;
  endtask
  task automatic test_random_display();
    logic [7:0] v [4];
    logic [31:0] w;
    logic [6:0] es;
    logic [3:0] ss;
    bit ok;
    do_reset();
    for (int it = 0; it < 3; it++) begin
      w = $urandom;
      bus_write(4'h3, w);
      for (int k = 0; k < 4; k++) begin
        v[k] = 8'($urandom);
        bus_write(4'(8 + k), {24'($urandom), v[k]});
      end
      sync_digit0(ok);
      n_chk++; if (!ok) $display("FAIL rnd_align got timeout exp digit0 slot"); else n_pass++;
      for (int t = 0; t < 16; t++) begin
        if (t > 0) tick();
        es = exp_seg(v[t / 4], w[0]);
        ss = ~(4'b0001 << (t / 4));
        n_chk++; if (sel !== ss || seg !== es) $display("FAIL rnd_scan it=%0d t=%0d got %b/%h exp %b/%h", it, t, sel, seg, ss, es); else n_pass++;
      end
    end
  endtask
  task automatic test_debounce();
    logic [31:0] d;
    int len;
    do_reset();
    for (int it = 0; it < 4; it++) begin
      len = (it == 0) ? 10 : int'($urandom_range(1, 15));
      pins[0] = 1'b1;
      repeat (len) tick();
      pins[0] = 1'b0;
      repeat (25) tick();
      bus_read(4'h0, d);
      n_chk++; if (d !== 32'h0) $display("FAIL glitch len=%0d got %h exp 0", len, d); else n_pass++;
    end
    bus.avs_address = 4'h0;
    bus.avs_read = 1'b1;
    pins[0] = 1'b1;
    for (int n = 0; n < 24; n++) begin
      tick();
      n_chk++; if (bus.avs_readdata !== ((n >= 18) ? 32'h1 : 32'h0)) $display("FAIL debounce n=%0d got %h exp %0d", n, bus.avs_readdata, n >= 18); else n_pass++;
    end
    bus.avs_read = 1'b0;
  endtask
  task automatic test_edge_irq();
    logic [31:0] d;
    do_reset();
    bus_write(4'h2, 32'h1);
    pins[0] = 1'b1;
    for (int n = 0; n < 24; n++) begin
      tick();
      n_chk++; if (irq !== (n >= 18)) $display("FAIL edge_irq n=%0d got %b exp %0d", n, irq, n >= 18); else n_pass++;
    end
    bus_read(4'h1, d);
    n_chk++; if (d !== 32'h1) $display("FAIL edge_set got %h exp 1", d); else n_pass++;
    bus_write(4'h1, 32'h1);
    tick();
    n_chk++; if (irq !== 1'b0) $display("FAIL w1c_irq got %b exp 0", irq); else n_pass++;
    bus_read(4'h1, d);
    n_chk++; if (d !== 32'h0) $display("FAIL w1c_edge got %h exp 0", d); else n_pass++;
    pins[1] = 1'b1;
    repeat (17) tick();
    bus_write(4'h1, 32'h2);
    bus_read(4'h1, d);
    n_chk++; if (d !== 32'h2) $display("FAIL set_wins got %h exp 2", d); else n_pass++;
  endtask
  task automatic test_random_inputs();
    logic [31:0] d, w;
    logic [3:0] mask, stab, edg, val;
    do_reset();
    mask = 4'($urandom);
    bus_write(4'h2, {28'($urandom), mask});
    stab = '0;
    edg = '0;
    for (int it = 0; it < 6; it++) begin
      val = 4'($urandom);
      pins = val;
      repeat (20) tick();
      edg = edg | (val & ~stab);
      stab = val;
      bus_read(4'h0, d);
      n_chk++; if (d !== 32'(stab)) $display("FAIL rnd_datain it=%0d got %h exp %h", it, d, stab); else n_pass++;
      bus_read(4'h1, d);
      n_chk++; if (d !== 32'(edg)) $display("FAIL rnd_edge it=%0d got %h exp %h", it, d, edg); else n_pass++;
      n_chk++; if (irq !== |(edg & mask)) $display("FAIL rnd_irq it=%0d got %b exp %b", it, irq, |(edg & mask)); else n_pass++;
      w = $urandom;
      bus_write(4'h1, w);
      edg = edg & ~w[3:0];
      tick();
      bus_read(4'h1, d);
      n_chk++; if (d !== 32'(edg)) $display("FAIL rnd_w1c it=%0d got %h exp %h", it, d, edg); else n_pass++;
      n_chk++; if (irq !== |(edg & mask)) $display("FAIL rnd_w1c_irq it=%0d got %b exp %b", it, irq, |(edg & mask)); else n_pass++;
    end
  endtask
  initial begin
    test_reset();
    test_bus();
    test_hex_scan();
    test_raw_blank();
    test_random_display();
    test_debounce();
    test_edge_irq();
    test_random_inputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pio_display_input_ctrl.md
Name: pio_display_input_ctrl

Overview:
Parametrised Avalon-MM PIO peripheral. It replaces the fixed single-digit display PIO and the fixed 4-bit password and 1-bit input PIOs with one block. The block drives a multiplexed N-digit 7-segment display, with hex-decode or raw mode per block. It debounces an IN_W-bit input port, with rising-edge capture and a maskable interrupt. It sits inside the platform system on the HPS lightweight bus.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
IN_W, 4, input port width (1..32)
DEBOUNCE_CYC, 16, cycles an input must stay stable before it is accepted (>=2)
SCAN_DIV, 1000, clock cycles per digit scan slot (>=2)

Ports:
clk_clk  in  1  system clock
rst_reset  in  1  synchronous active-high reset
avs_address  in  4  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, registered
irq  out  1  level interrupt, active high
in_pins  in  IN_W  asynchronous external inputs (switches/keys)
seg_out  out  7  segments {g,f,e,d,c,b,a}, active low
digit_sel_n  out  DIGITS  digit enables, active low, one-hot

Behaviour:
Register map (word addresses):
- 0x0 DATA_IN: read-only; debounced input in [IN_W-1:0], zero-extended.
- 0x1 EDGE: read; write-1-to-clear; captured rising edges.
- 0x2 IRQ_MASK: read/write, [IN_W-1:0].
- 0x3 MODE: read/write, bit0. 0 = hex decode, 1 = raw segments.
- 0x8+k DIGIT[k], k < DIGITS: read/write, bits [7:0]. Bit7 = blank; [6:0] = raw segments (active high); [3:0] = hex nibble.
- All other addresses read 0; writes to them and to DATA_IN are ignored. Bits above the defined width read 0.

Bus rules:
- Read latency is 1: avs_readdata is valid the cycle after avs_read and holds until the next read.
- A write takes effect on the clock edge where avs_write=1. No wait states.

Input path, per bit:
- 2-flop synchroniser, then debouncer.
- Counter rules: if sync != stable, the counter increments; else the counter clears.
- When the counter reaches DEBOUNCE_CYC-1 with sync still != stable: stable <= sync, counter clears.
- A glitch shorter than DEBOUNCE_CYC cycles never reaches stable.
- Total latency from a pin change to DATA_IN is 2 + DEBOUNCE_CYC cycles.
- EDGE[i] sets on the stable 0->1 transition.
- W1C clears EDGE bits. If a set and a clear hit the same bit in the same cycle, set wins.
- irq is registered: irq <= |(EDGE & IRQ_MASK). It asserts one cycle after EDGE/MASK become nonzero.

Display scan:
- Prescaler counts 0..SCAN_DIV-1. At terminal count, the digit index advances; it wraps from DIGITS-1 to 0.
- digit_sel_n and seg_out are registered from the current index and DIGIT register, one cycle after the index changes.
- Segment value: if blank, 7'h7F. Else if MODE=1, ~DIGIT[6:0]. Else hex-decode [3:0].
- Hex-decode table, active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- A DIGIT write is visible at the next output register update, with no tearing within a slot.

Reset, synchronous, all state:
- DIGIT[k] = 0x80 (blank); MODE = 0; IRQ_MASK = 0; EDGE = 0.
- Debounce stable = 0; counters, prescaler and index = 0.
- Outputs: avs_readdata = 0, irq = 0, seg_out = 7'h7F, digit_sel_n = ~1 (digit 0 selected).
- Reset mid-debounce discards the pending change.
- Reset mid-scan returns the scan to digit 0.

Test Plan:
- Reset: after rst_reset, seg_out=7F, digit_sel_n=4'b1110, irq=0, and every register reads its reset value.
- Hex scan (SCAN_DIV=4): write DIGIT0..3 = 0x01, 0x0A, 0x0F, 0x08. Required: seg_out cycles 79, 08, 0E, 00 with digit_sel_n 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to digit 0.
- Raw and blank: MODE=1, DIGIT0=0x7F -> seg_out=00. Then DIGIT0=0x80 -> seg_out=7F.
- Debounce (DEBOUNCE_CYC=16): a 10-cycle pulse on in_pins[0] leaves DATA_IN=0. A held high sets DATA_IN=1 exactly 18 cycles after the pin change.
- Edge and IRQ: IRQ_MASK=0x1, then in_pins[0] rises -> EDGE=1 and irq=1 one cycle later. Write EDGE=1 -> irq=0. A W1C issued in the same cycle as a new edge leaves EDGE=1.
- Bus: reading 0x5 returns 0. Writing DATA_IN leaves it unchanged. Readdata appears exactly 1 cycle after avs_read.
